// File: rtl/alu_serial.sv
// ---------------------------------------------------------------------------
// alu_serial
//
// Nibble-serial ALU. An accepted start latches both operands, the op code,
// the invert-B control and a carry/shift-in bit. The datapath then handles
// one 4-bit slice per RUN cycle, so an operation takes WIDTH/4 cycles. The
// finished result and flags are loaded into their output registers at the
// RUN->DONE transition and stay there until the next completion.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     operation request, sampled only when not busy
//   a, b      operands (WIDTH bits), latched on an accepted start
//   op        operation code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 SHR,
//             6/7 PASS A
//   invert    use ~b in place of b
//   carry_in  carry-in for ADD, shift-in bit for SHL/SHR
//   oe        active-high output disable (1 = result bus high-Z)
//   busy      high for the whole of RUN
//   done      one-cycle completion pulse (the DONE state)
//   result    registered result; high-Z while oe = 1
//   flags     registered flags {overflow, sign, carry, zero}
// ---------------------------------------------------------------------------
module alu_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             invert,
    input  logic             carry_in,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int NIB    = WIDTH / 4;
    localparam int STEP_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NIB - 1);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [STEP_W-1:0] step_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [2:0]        op_r;
    logic              link_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  result_r;
    logic [3:0]        flags_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              run_s;
    logic              last_s;
    logic [STEP_W-1:0] idx_s;
    logic [STEP_W+1:0] base_s;
    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        sum5_s;
    logic [3:0]        slice_s;
    logic              link_next_s;
    logic              ovf_s;
    logic [WIDTH-1:0]  acc_next_s;
    logic [3:0]        flags_next_s;

    assign accept_s = start && (state_r != S_RUN);
    assign run_s    = (state_r == S_RUN);
    assign last_s   = run_s && (step_r == LAST_STEP);

    // Slice selection: SHR walks MSB-first so the shift-in bit enters at the top.
    always_comb begin
        if (op_r == OP_SHR) begin
            idx_s = LAST_STEP - step_r;
        end else begin
            idx_s = step_r;
        end
        base_s  = {idx_s, 2'b00};
        a_nib_s = a_r[base_s +: 4];
        b_nib_s = b_r[base_s +: 4];
    end

    // One-nibble datapath; link_next_s is the bit handed to the next slice.
    always_comb begin
        sum5_s      = 5'd0;
        slice_s     = 4'd0;
        link_next_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                sum5_s      = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'd0, link_r};
                slice_s     = sum5_s[3:0];
                link_next_s = sum5_s[4];
            end
            OP_AND: slice_s = a_nib_s & b_nib_s;
            OP_OR:  slice_s = a_nib_s | b_nib_s;
            OP_XOR: slice_s = a_nib_s ^ b_nib_s;
            OP_SHL: begin
                slice_s     = {a_nib_s[2:0], link_r};
                link_next_s = a_nib_s[3];
            end
            OP_SHR: begin
                slice_s     = {link_r, a_nib_s[3:1]};
                link_next_s = a_nib_s[0];
            end
            default: slice_s = a_nib_s;
        endcase
    end

    // Merge the current slice into the accumulator and form the final flags.
    // Overflow is only meaningful on the top slice, which is where it is used.
    always_comb begin
        acc_next_s               = acc_r;
        acc_next_s[base_s +: 4]  = slice_s;
        if (op_r == OP_ADD) begin
            ovf_s = (a_nib_s[3] == b_nib_s[3]) && (slice_s[3] != a_nib_s[3]);
        end else begin
            ovf_s = 1'b0;
        end
        flags_next_s = {ovf_s, acc_next_s[WIDTH-1], link_next_s,
                        (acc_next_s == {WIDTH{1'b0}})};
    end

    // Next-state logic for the IDLE/RUN/DONE controller.
    always_comb begin
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Controller state plus registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Step counter: cleared on acceptance, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= {STEP_W{1'b0}};
        end else if (accept_s) begin
            step_r <= {STEP_W{1'b0}};
        end else if (run_s && !last_s) begin
            step_r <= step_r + STEP_W'(1);
        end
    end

    // Operand capture on acceptance; B is stored already inverted when asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
            op_r <= 3'd0;
        end else if (accept_s) begin
            a_r  <= a;
            b_r  <= invert ? ~b : b;
            op_r <= op;
        end
    end

    // Link bit and partial-result accumulator, updated slice by slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_r <= 1'b0;
            acc_r  <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            link_r <= carry_in;
            acc_r  <= {WIDTH{1'b0}};
        end else if (run_s) begin
            link_r <= link_next_s;
            acc_r  <= acc_next_s;
        end
    end

    // Visible result and flags load only on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            flags_r  <= 4'd0;
        end else if (last_s) begin
            result_r <= acc_next_s;
            flags_r  <= flags_next_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign flags  = flags_r;
    assign result = oe ? {WIDTH{1'bz}} : result_r;

endmodule

// File: tb/tb_alu_serial.sv
// ---------------------------------------------------------------------------
// tb_alu_serial
//
// Directed bench for alu_serial (WIDTH = 16). Each accepted operation pushes
// its expected result/flags and acceptance cycle into a scoreboard queue; a
// monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_serial;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] a        = 16'h0000;
    logic [15:0] b        = 16'h0000;
    logic [2:0]  op       = 3'd0;
    logic        invert   = 1'b0;
    logic        carry_in = 1'b0;
    logic        oe       = 1'b0;
    wire         busy;
    wire         done;
    wire  [15:0] result;
    wire  [3:0]  flags;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          n_done   = 0;
    int          n_done0  = 0;
    logic [15:0] held_res = 16'h0000;
    logic [19:0] m;

    alu_serial #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .invert   (invert),
        .carry_in (carry_in),
        .oe       (oe),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, returns {result, ovf, sign, carry, zero}.
    function automatic logic [19:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                          input logic [2:0] fop, input logic finv,
                                          input logic fcin);
        logic [15:0] bb;
        logic [15:0] r;
        logic [16:0] s;
        logic        c;
        logic        v;
        bb = finv ? ~fb : fb;
        r  = fa;
        c  = 1'b0;
        v  = 1'b0;
        case (fop)
            3'd0: begin
                s = {1'b0, fa} + {1'b0, bb} + {16'd0, fcin};
                r = s[15:0];
                c = s[16];
                v = (fa[15] == bb[15]) && (r[15] != fa[15]);
            end
            3'd1: r = fa & bb;
            3'd2: r = fa | bb;
            3'd3: r = fa ^ bb;
            3'd4: begin r = {fa[14:0], fcin}; c = fa[15]; end
            3'd5: begin r = {fcin, fa[15:1]}; c = fa[0];  end
            default: r = fa;
        endcase
        return {r, v, r[15], c, (r == 16'h0000)};
    endfunction

    // Monitor: checks each done against the scoreboard, and that result holds while busy.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && done) begin
            n_done++;
            chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("latency", 32'(cyc - mon_e.acc_cyc), 32'(NIB));
                chk("flags", 32'(flags), 32'(mon_e.flg));
                if (!oe) begin
                    chk("result", 32'(result), 32'(mon_e.res));
                end
                held_res = mon_e.res;
            end
        end
        if (rst_n && busy && !oe) begin
            chk("result_hold", 32'(result), 32'(held_res));
        end
    end

    // Called just after a negedge; drives start for one edge, then scrambles inputs.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top,
                         input logic tinv, input logic tcin);
        exp_t e;
        logic [19:0] mm;
        a = ta; b = tb_v; op = top; invert = tinv; carry_in = tcin;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        op       = 3'($urandom);
        invert   = 1'($urandom);
        carry_in = 1'($urandom);
        mm        = model(ta, tb_v, top, tinv, tcin);
        e.res     = mm[19:4];
        e.flg     = mm[3:0];
        e.acc_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'h0000);
        chk("rst_flags",  32'(flags),  32'h0);
        @(negedge clk);
        @(negedge clk);

        // First start right at reset release
        rst_n = 1'b1;
        issue(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0);
        chk("busy_first", 32'(busy), 32'd1);
        drain("drain_add");
        issue(16'h8000, 16'h0001, 3'd0, 1'b1, 1'b1);
        drain("drain_sub");
        issue(16'h8001, 16'h0000, 3'd5, 1'b0, 1'b1);
        drain("drain_shr");
        issue(16'h8001, 16'h0000, 3'd4, 1'b0, 1'b0);
        drain("drain_shl");

        // Spot-check the reference itself against the listed vectors
        m = model(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0);
        chk("vec_add", 32'(m), 32'h00003);
        m = model(16'h8001, 16'h0000, 3'd5, 1'b0, 1'b1);
        chk("vec_shr", 32'(m), 32'hC0006);

        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 16'($urandom), 3'(i), 1'($urandom), 1'($urandom));
            drain("drain_rand");
        end

        // start during RUN is ignored; start during DONE is accepted
        issue(16'h1234, 16'h0F0F, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_k4", 32'(done), 32'd1);
        issue(16'h8000, 16'h0001, 3'd0, 1'b1, 1'b1);
        chk("busy_b2b", 32'(busy), 32'd1);
        chk("done_b2b", 32'(done), 32'd0);
        drain("drain_b2b");

        // Reset in RUN step 2 aborts the operation
        issue(16'h1111, 16'h2222, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb_q.pop_back());
        held_res = 16'h0000;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_result", 32'(result), 32'h0000);
        chk("abort_flags",  32'(flags),  32'h0);
        n_done0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(n_done - n_done0), 32'd0);

        // Output disable during and after an operation
        oe = 1'b1;
        issue(16'h8F0F, 16'h7070, 3'd2, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("oe_done",  32'(done),  32'd1);
        chk("oe_flags", 32'(flags), 32'h4);
        chk("oe_hiz",   32'(result !== 16'hFF7F), 32'd1);
        oe = 1'b0;
        #1;
        chk("oe_restore", 32'(result), 32'hFF7F);
        @(negedge clk);
        chk("oe_done_drop", 32'(done),   32'd0);
        chk("oe_hold",      32'(result), 32'hFF7F);

        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4, minimum 8.
REQ-002 Derived constant: NIB = WIDTH/4, number of nibble steps per operation.
REQ-003 Clock and reset: one clock, reset asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request; sampled only when not busy.
REQ-007 a  input  WIDTH  operand A, latched on accepted start.
REQ-008 b  input  WIDTH  operand B, latched on accepted start.
REQ-009 op  input  3  operation code, latched on accepted start.
REQ-010 invert  input  1  invert B before use, latched on accepted start.
REQ-011 carry_in  input  1  carry/shift-in bit, latched on accepted start.
REQ-012 oe  input  1  active-high output disable; 1 = result high-Z.
REQ-013 busy  output  1  operation in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 result  output  WIDTH  registered result, high-Z when oe=1.
REQ-016 flags  output  4  registered flags: [0] zero, [1] carry, [2] sign, [3] overflow.

Function
REQ-017 Ops (B' = invert ? ~b : b): 0 ADD A+B'+carry_in; 1 AND A&B'; 2 OR A|B'; 3 XOR A^B'; 4 SHL A<<1, carry_in into bit 0; 5 SHR A>>1, carry_in into bit WIDTH-1; 6,7 PASS A.
REQ-018 Processing SHALL be nibble-serial: exactly one 4-bit slice computed per RUN cycle; no full-width adder/shifter.
REQ-019 ADD, AND, OR, XOR, SHL, PASS SHALL process nibbles LSB-first; SHR SHALL process MSB-first; a 1-bit link register carries the carry/shift bit between slices.
REQ-020 States: IDLE, RUN, DONE; IDLE/DONE + start -> RUN (operands latched, step count 0); RUN -> RUN while step < NIB-1; RUN at step NIB-1 -> DONE; DONE without start -> IDLE.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-022 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+NIB.
REQ-023 start in RUN SHALL be ignored, with no effect on operands or timing.
REQ-024 start in DONE SHALL be accepted (back-to-back), done still pulsing that cycle.
REQ-025 result and flags SHALL update only at the RUN->DONE transition and hold until the next completion; partial slices SHALL NOT appear on result.
REQ-026 zero = all WIDTH result bits 0, for every op.
REQ-027 carry: ADD = carry out of bit WIDTH-1; SHL = A[WIDTH-1]; SHR = A[0]; other ops 0.
REQ-028 sign = result[WIDTH-1], for every op.
REQ-029 overflow: ADD = signed overflow of A+B'+carry_in; other ops 0.
REQ-030 Inputs other than start SHALL be don't-care outside the accepting cycle.
REQ-031 oe SHALL be combinational on result only; it SHALL NOT affect state, busy, done or flags.

Reset
REQ-032 rst_n=0 SHALL force IDLE, busy=0, done=0, result register 0, flags 0, link and step counter 0, immediately and regardless of clk.
REQ-033 Reset during RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-034 After rst_n release the first start SHALL be accepted on the first clk edge.

Verification (WIDTH=16, NIB=4)
REQ-035 ADD a=0xFFFF b=0x0001 inv=0 cin=0 -> after 4 RUN cycles done=1, result 0x0000, flags 0b0011.
REQ-036 SUB a=0x8000 b=0x0001 inv=1 cin=1 -> result 0x7FFF, flags 0b1010 (carry, overflow).
REQ-037 SHR a=0x8001 cin=1 -> result 0xC000, flags 0b0110; SHL a=0x8001 cin=0 -> 0x0002, flags 0b0010.
REQ-038 start pulsed each cycle of RUN with different operands -> first op's result only, done exactly 4 cycles after acceptance; start in DONE -> new op accepted, busy next cycle.
REQ-039 rst_n low in RUN step 2 -> busy=0, done never asserts, result 0x0000, flags 0.
REQ-040 oe=1 after completion -> result all Z, flags/done unchanged; oe=0 -> held value returns.
